// File: rtl/rx_package.sv
// Shared receiver-path widths and the sweep controller state encoding.
package rx_package;
  localparam int RX_SETTING_WIDTH = 4;
  localparam int ERR_CNT_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CAPTURE,
    ST_NEXT,
    ST_DONE
  } sweep_state_e;
endpackage

// File: rtl/sweep_ctrl.sv
// Steps rx_setting across [min, max], resets and runs the emulator at each
// point, and keeps the setting that produced the lowest bit-error count.
module sweep_ctrl
  import rx_package::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int TMO_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [RX_SETTING_WIDTH-1:0] setting_min,
  input  logic [RX_SETTING_WIDTH-1:0] setting_max,
  input  logic [TMO_WIDTH-1:0]        tmo_limit,
  input  logic                        time_flag,
  input  logic [ERR_CNT_WIDTH-1:0]    err_cnt,
  output logic                        rst_dut,
  output logic [RX_SETTING_WIDTH-1:0] rx_setting,
  output logic                        busy,
  output logic                        done,
  output logic                        best_valid,
  output logic [RX_SETTING_WIDTH-1:0] best_setting,
  output logic [ERR_CNT_WIDTH-1:0]    best_err
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  sweep_state_e                state_q, state_d;
  logic [RX_SETTING_WIDTH-1:0] rx_q, rx_d;
  logic [RX_SETTING_WIDTH-1:0] max_q, max_d;
  logic [TMO_WIDTH-1:0]        tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0]        run_cnt_q, run_cnt_d;
  logic [7:0]                  rst_cnt_q, rst_cnt_d;
  logic                        timeout_q, timeout_d;
  logic                        rst_dut_q, rst_dut_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        bv_q, bv_d;
  logic [RX_SETTING_WIDTH-1:0] bs_q, bs_d;
  logic [ERR_CNT_WIDTH-1:0]    be_q, be_d;
  logic [ERR_CNT_WIDTH-1:0]    eff_err;

  assign eff_err = timeout_q ? '1 : err_cnt;

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    max_d     = max_q;
    tmo_d     = tmo_q;
    run_cnt_d = run_cnt_q;
    rst_cnt_d = rst_cnt_q;
    timeout_d = timeout_q;
    rst_dut_d = rst_dut_q;
    busy_d    = busy_q;
    done_d    = done_q;
    bv_d      = bv_q;
    bs_d      = bs_q;
    be_d      = be_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          max_d = setting_max;
          tmo_d = tmo_limit;
          bv_d  = 1'b0;
          if (setting_min <= setting_max) begin
            state_d   = ST_RESET;
            rx_d      = setting_min;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            rst_dut_d = 1'b1;
            rst_cnt_d = '0;
          end else begin
            // Empty range: finish without touching rst_dut, so an emulator
            // still held from IDLE is never released.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_RUN;
          rst_dut_d = 1'b0;
          run_cnt_d = '0;
          timeout_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (time_flag) begin
          state_d   = ST_CAPTURE;
          timeout_d = 1'b0;
        end else if (run_cnt_q == tmo_q) begin
          state_d   = ST_CAPTURE;
          timeout_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Strict compare: on ties the earlier (lower) setting stays best.
        if (!bv_q || (eff_err < be_q)) begin
          bv_d = 1'b1;
          bs_d = rx_q;
          be_d = eff_err;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (rx_q == max_q) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rst_dut_d = 1'b0;
        end else begin
          state_d   = ST_RESET;
          rx_d      = rx_q + 1'b1;
          rst_dut_d = 1'b1;
          rst_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rx_q      <= '0;
      max_q     <= '0;
      tmo_q     <= '0;
      run_cnt_q <= '0;
      rst_cnt_q <= '0;
      timeout_q <= 1'b0;
      rst_dut_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bv_q      <= 1'b0;
      bs_q      <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      max_q     <= max_d;
      tmo_q     <= tmo_d;
      run_cnt_q <= run_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      timeout_q <= timeout_d;
      rst_dut_q <= rst_dut_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bv_q      <= bv_d;
      bs_q      <= bs_d;
      be_q      <= be_d;
    end
  end

  assign rst_dut      = rst_dut_q;
  assign rx_setting   = rx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign best_valid   = bv_q;
  assign best_setting = bs_q;
  assign best_err     = be_q;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: DUT reset hold length in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter TMO_WIDTH, default 32: width of the per-point run timeout counter.
REQ-003 SHALL have port clk  input  1  system clock (clk_sys domain); one clock only.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port setting_min  input  RX_SETTING_WIDTH  first rx_setting of the sweep.
REQ-007 SHALL have port setting_max  input  RX_SETTING_WIDTH  last rx_setting of the sweep, inclusive.
REQ-008 SHALL have port tmo_limit  input  TMO_WIDTH  maximum RUN cycles per point.
REQ-009 SHALL have port time_flag  input  1  emulator run-complete flag (time_curr >= time_trig).
REQ-010 SHALL have port err_cnt  input  ERR_CNT_WIDTH  unsigned bit-error count from the external checker.
REQ-011 SHALL have port rst_dut  output  1  reset driven into the emulator datapath.
REQ-012 SHALL have port rx_setting  output  RX_SETTING_WIDTH  current sweep point.
REQ-013 SHALL have port busy, done, best_valid  output  1 each  sweep status.
REQ-014 SHALL have port best_setting  output  RX_SETTING_WIDTH  setting with the lowest error count.
REQ-015 SHALL have port best_err  output  ERR_CNT_WIDTH  error count at best_setting.

Function
REQ-016 SHALL implement FSM states IDLE, RESET, RUN, CAPTURE, NEXT, DONE; all outputs registered.
REQ-017 IDLE: start=1 and setting_min<=setting_max -> RESET next cycle; rx_setting<=setting_min; best_valid<=0; busy<=1; done<=0.
REQ-018 IDLE: start=1 and setting_min>setting_max -> DONE directly; best_valid=0.
REQ-019 RESET: rst_dut=1 for exactly RST_CYCLES cycles, then -> RUN; rst_dut falls on the same edge as the RUN entry.
REQ-020 RUN: rst_dut=0; timeout counter starts at 0 on entry and increments every cycle.
REQ-021 RUN: time_flag=1 -> CAPTURE.
REQ-022 RUN: counter==tmo_limit with time_flag=0 -> CAPTURE with timeout marked; time_flag takes priority on the same cycle.
REQ-023 CAPTURE: one cycle; effective error = all-ones if timeout, else err_cnt.
REQ-024 CAPTURE: if best_valid=0 or effective error < best_err (strict), load best_setting<=rx_setting, best_err<=effective error, best_valid<=1; ties keep the earlier (lower) setting.
REQ-025 NEXT: if rx_setting==setting_max -> DONE; else rx_setting<=rx_setting+1 and -> RESET.
REQ-026 Sweep SHALL terminate when setting_max is all-ones; rx_setting SHALL never wrap.
REQ-027 DONE: busy=0, done=1 (level), rst_dut=0; results held; start=1 -> IDLE behaviour of REQ-017/018 (restart).
REQ-028 start SHALL be ignored in RESET, RUN, CAPTURE and NEXT.
REQ-029 setting_min, setting_max and tmo_limit SHALL be sampled on start acceptance; later changes SHALL not affect the sweep in progress.
REQ-030 busy SHALL be 1 exactly in RESET, RUN, CAPTURE and NEXT.

Reset
REQ-031 rst=1 SHALL force IDLE from any state, including mid-sweep, on the next edge.
REQ-032 Reset values: rst_dut=1, rx_setting=0, busy=0, done=0, best_valid=0, best_setting=0, best_err=0, counters=0.
REQ-033 rst_dut SHALL remain 1 in IDLE so the emulator is held reset until a sweep starts.

Structure
REQ-034 ERR_CNT_WIDTH and the state enum typedef SHALL live in rx_package; RX_SETTING_WIDTH SHALL be reused from rx_package.
REQ-035 The block SHALL be a single module with no sub-modules.
REQ-036 The block SHALL be instantiated in the top level between the VIO and rst_gen; it drives rst and rx_setting in place of the VIO.

Verification
REQ-037 min=2, max=4, RST_CYCLES=16, err 7,3,5, time_flag 100 cycles after RUN entry -> best_setting=3, best_err=3, done=1, three 16-cycle rst_dut pulses.
REQ-038 Errors 4,4,4 over settings 0..2 -> best_setting=0 (tie keeps lowest).
REQ-039 tmo_limit=50, time_flag never asserted at setting 1 -> CAPTURE after 51 RUN cycles, effective error all-ones, setting 1 never best unless all points time out.
REQ-040 min=5, max=3, start -> DONE next cycle, best_valid=0, no rst_dut release.
REQ-041 rst=1 during RUN of the second point -> IDLE next cycle, rst_dut=1, busy=0, best_valid=0; restart reproduces the REQ-037 result.
REQ-042 min=max=all-ones -> single point, DONE, rx_setting stays all-ones (no wrap); start pulses during RUN are ignored.
